audio_stream_ctrl: RTL and testbench

- Sequences one stereo sample at a time through the audio codec handshake into the filter stage and back out to the codec.
- Sits between audio_codec and the per-channel filter instances.
- Replaces free-running read/write flag wiring with an FSM that:
  - issues single-cycle read/write pulses,
  - strobes the filter once per sample,
  - holds write data stable,
  - counts timeouts and overruns.

---
 rtl/audio_stream_if.sv | 36 +++
 rtl/audio_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_audio_stream_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_stream_if.sv
// Codec and filter handshake bundle for audio_stream_ctrl.
// The master is the controller; the slave is the codec/filter side.
interface audio_stream_if #(
   parameter int W = 24
);
   // codec side
   logic         read_ready;
   logic         write_ready;
   logic [W-1:0] readdata_left;
   logic [W-1:0] readdata_right;
   logic         read;
   logic         write;
   logic [W-1:0] writedata_left;
   logic [W-1:0] writedata_right;
   // filter side
   logic         proc_valid;
   logic [W-1:0] proc_left;
   logic [W-1:0] proc_right;
   logic         proc_done;
   logic [W-1:0] proc_out_left;
   logic [W-1:0] proc_out_right;

   modport master (
      input  read_ready, write_ready, readdata_left, readdata_right,
             proc_done, proc_out_left, proc_out_right,
      output read, write, writedata_left, writedata_right,
             proc_valid, proc_left, proc_right
   );

   modport slave (
      output read_ready, write_ready, readdata_left, readdata_right,
             proc_done, proc_out_left, proc_out_right,
      input  read, write, writedata_left, writedata_right,
             proc_valid, proc_left, proc_right
   );
endinterface

// File: rtl/audio_stream_ctrl.sv
// One stereo sample at a time: codec read -> filter (or bypass) -> codec write.
// Every output is a register; the combinational process only decides what
// the registers load on the next edge.
module audio_stream_ctrl #(
   parameter int W       = 24,
   parameter int TIMEOUT = 64,
   parameter int CW      = 8
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic          enable,
   input  logic          bypass,
   audio_stream_if.master bus,
   output logic          busy,
   output logic [CW-1:0] timeout_cnt,
   output logic [CW-1:0] overrun_cnt
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CAPTURE, PROCESS, WR_WAIT, WRITE} state_t;

   state_t        state, state_d;
   logic          byp_q;        // bypass frozen at transaction start
   logic          rr_q;         // read_ready delayed for edge detect
   logic [TW-1:0] timer;

   logic start, ld_raw, ld_filt, tmo, tmr_clr, tmr_inc;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) state <= IDLE;
      else         state <= state_d;
   end

   // Next-state and load strobes
   always_comb begin
      state_d = state;
      start   = 1'b0;
      ld_raw  = 1'b0;
      ld_filt = 1'b0;
      tmo     = 1'b0;
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      case (state)
         IDLE:
            if (enable && bus.read_ready) begin
               start   = 1'b1;
               state_d = CAPTURE;
            end
         CAPTURE:
            if (byp_q) begin
               ld_raw  = 1'b1;
               state_d = WR_WAIT;
            end else begin
               tmr_clr = 1'b1;
               state_d = PROCESS;
            end
         PROCESS:
            // a result arriving on the last allowed cycle still wins
            if (bus.proc_done) begin
               ld_filt = 1'b1;
               state_d = WR_WAIT;
            end else if (timer == T_LAST) begin
               ld_raw  = 1'b1;
               tmo     = 1'b1;
               state_d = WR_WAIT;
            end else begin
               tmr_inc = 1'b1;
            end
         WR_WAIT:
            if (bus.write_ready) state_d = WRITE;
         WRITE:
            state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // Registered outputs, sample latches, timer and status counters
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         bus.read            <= 1'b0;
         bus.write           <= 1'b0;
         bus.proc_valid      <= 1'b0;
         bus.proc_left       <= '0;
         bus.proc_right      <= '0;
         bus.writedata_left  <= '0;
         bus.writedata_right <= '0;
         busy                <= 1'b0;
         byp_q               <= 1'b0;
         rr_q                <= 1'b0;
         timer               <= '0;
         timeout_cnt         <= '0;
         overrun_cnt         <= '0;
      end else begin
         // strobes land in the cycle the FSM spends in CAPTURE / WRITE
         bus.read       <= start;
         bus.proc_valid <= start & ~bypass;
         bus.write      <= (state == WR_WAIT) && bus.write_ready;
         busy           <= (state_d != IDLE);
         rr_q           <= bus.read_ready;

         if (start) begin
            bus.proc_left  <= bus.readdata_left;
            bus.proc_right <= bus.readdata_right;
            byp_q          <= bypass;
         end

         if (ld_raw) begin
            bus.writedata_left  <= bus.proc_left;
            bus.writedata_right <= bus.proc_right;
         end else if (ld_filt) begin
            bus.writedata_left  <= bus.proc_out_left;
            bus.writedata_right <= bus.proc_out_right;
         end

         if (tmr_clr)      timer <= '0;
         else if (tmr_inc) timer <= timer + 1'b1;

         if (tmo && timeout_cnt != '1)
            timeout_cnt <= timeout_cnt + 1'b1;

         // new sample offered while the previous one is still in flight
         if (bus.read_ready && !rr_q && busy && overrun_cnt != '1)
            overrun_cnt <= overrun_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl. Expected write pairs go into a
// queue at stimulus time; a monitor pops one per write pulse and compares.
module tb_audio_stream_ctrl;
   localparam int W = 24, TIMEOUT = 64, CW = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic          bypass = 1'b0;
   logic          busy;
   logic [CW-1:0] tcnt, ocnt;

   audio_stream_if #(.W(W)) bus ();

   audio_stream_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .enable     (enable),
      .bypass     (bypass),
      .bus        (bus),
      .busy       (busy),
      .timeout_cnt(tcnt),
      .overrun_cnt(ocnt)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int rd_cnt = 0, wr_cnt = 0, pv_cnt = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check(nm, 64'(busy), 64'd0);
   endtask

   task automatic start_txn(input logic byp, input logic [W-1:0] l, input logic [W-1:0] r);
      bypass             = byp;
      bus.readdata_left  = l;
      bus.readdata_right = r;
      bus.read_ready     = 1'b1;
      tick();
      bus.read_ready     = 1'b0;
   endtask

   // Scoreboard side: one pop per write pulse, read/write exclusivity
   task automatic monitor();
      logic [2*W-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.read)       rd_cnt++;
         if (bus.proc_valid) pv_cnt++;
         if (bus.read || bus.write)
            check("rd_wr_excl", 64'(bus.read & bus.write), 64'd0);
         if (bus.write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("writedata", 64'({bus.writedata_left, bus.writedata_right}), 64'(e));
            end
         end
      end
   endtask

   initial begin
      int r0, w0, p0;
      bus.read_ready     = 1'b0;
      bus.write_ready    = 1'b1;
      bus.readdata_left  = '0;
      bus.readdata_right = '0;
      bus.proc_done      = 1'b0;
      bus.proc_out_left  = '0;
      bus.proc_out_right = '0;

      fork
         monitor();
         begin
            #1ms;
            $display("FAIL watchdog: simulation time limit reached, expected completion");
            $fatal(1, "watchdog");
         end
      join_none

      // reset state
      tick(2);
      check("rst_busy",  64'(busy), 0);
      check("rst_read",  64'(bus.read), 0);
      check("rst_write", 64'(bus.write), 0);
      check("rst_pv",    64'(bus.proc_valid), 0);
      check("rst_wd",    64'({bus.writedata_left, bus.writedata_right}), 0);
      check("rst_cnt",   64'({tcnt, ocnt}), 0);
      resetn = 1'b1;
      enable = 1'b1;
      tick();

      // bypass: read at +1, write at +3, no filter strobe; late bypass change ignored
      exp_q.push_back({24'h123456, 24'hFEDCBA});
      start_txn(1'b1, 24'h123456, 24'hFEDCBA);
      check("byp_read_p1", 64'(bus.read), 1);
      bypass = 1'b0;
      tick();
      check("byp_read_p2", 64'(bus.read), 0);
      check("byp_write_p2", 64'(bus.write), 0);
      tick();
      check("byp_write_p3", 64'(bus.write), 1);
      tick();
      check("byp_write_p4", 64'(bus.write), 0);
      wait_idle("byp_idle");
      check("byp_no_pv", 64'(pv_cnt), 0);

      // filter result 5 cycles after proc_valid
      exp_q.push_back({24'h000008, 24'h000004});
      start_txn(1'b0, 24'h000010, 24'h000020);
      check("flt_pv", 64'(bus.proc_valid), 1);
      check("flt_proc_left", 64'(bus.proc_left), 64'h10);
      tick(4);
      bus.proc_out_left  = 24'h000008;
      bus.proc_out_right = 24'h000004;
      bus.proc_done      = 1'b1;
      tick();
      bus.proc_done      = 1'b0;
      wait_idle("flt_idle");
      check("flt_pv_once", 64'(pv_cnt), 1);
      check("flt_tcnt", 64'(tcnt), 0);

      // minimum filter latency; proc_done in CAPTURE ignored, accepted in first PROCESS
      exp_q.push_back({24'h0000AA, 24'h0000BB});
      bus.proc_out_left  = 24'h0000AA;
      bus.proc_out_right = 24'h0000BB;
      start_txn(1'b0, 24'h000001, 24'h000002);
      bus.proc_done = 1'b1;
      tick(2);
      bus.proc_done = 1'b0;
      tick();
      check("lat4_write", 64'(bus.write), 1);
      wait_idle("lat4_idle");

      // timeout: 64 PROCESS cycles then raw sample goes out
      exp_q.push_back({24'h0ABCDE, 24'h800001});
      start_txn(1'b0, 24'h0ABCDE, 24'h800001);
      tick(64);
      check("tmo_not_yet", 64'(tcnt), 0);
      check("tmo_busy", 64'(busy), 1);
      tick();
      check("tmo_cnt1", 64'(tcnt), 1);
      check("tmo_no_write", 64'(bus.write), 0);
      tick();
      check("tmo_write", 64'(bus.write), 1);
      wait_idle("tmo_idle");

      // saturate timeout_cnt
      for (int i = 1; i < 300; i++) begin
         exp_q.push_back({W'(i), W'(~i)});
         start_txn(1'b0, W'(i), W'(~i));
         wait_idle("tmo_loop_idle");
         if (i == 254) check("tmo_cnt255", 64'(tcnt), 255);
      end
      check("tmo_sat", 64'(tcnt), 255);

      // overrun while stuck in WR_WAIT
      w0 = wr_cnt;
      bus.write_ready = 1'b0;
      exp_q.push_back({24'h0F0F0F, 24'h707070});
      start_txn(1'b1, 24'h0F0F0F, 24'h707070);
      for (int c = 0; c < 100; c++) begin
         bus.read_ready = (c % 30 >= 10 && c % 30 < 13 && c < 90);
         tick();
      end
      bus.read_ready = 1'b0;
      check("ovr_cnt", 64'(ocnt), 3);
      check("ovr_busy", 64'(busy), 1);
      check("ovr_no_write", 64'(wr_cnt - w0), 0);
      bus.write_ready = 1'b1;
      wait_idle("ovr_idle");
      tick();
      check("ovr_one_write", 64'(wr_cnt - w0), 1);

      // reset during PROCESS; late proc_done ignored
      w0 = wr_cnt;
      start_txn(1'b0, 24'h055555, 24'h066666);
      tick(2);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_wd", 64'({bus.writedata_left, bus.writedata_right}), 0);
      check("mid_rst_cnt", 64'({tcnt, ocnt}), 0);
      check("mid_rst_pl", 64'(bus.proc_left), 0);
      bus.proc_done = 1'b1;
      tick();
      bus.proc_done = 1'b0;
      tick(3);
      check("late_done_busy", 64'(busy), 0);
      check("late_done_wd", 64'({bus.writedata_left, bus.writedata_right}), 0);
      check("late_done_nowr", 64'(wr_cnt - w0), 0);

      // enable dropped mid-transaction: finish, then no new start
      r0 = rd_cnt; w0 = wr_cnt; p0 = pv_cnt;
      exp_q.push_back({24'h00AAAA, 24'h00BBBB});
      start_txn(1'b0, 24'h000111, 24'h000222);
      tick();
      enable             = 1'b0;
      bus.read_ready     = 1'b1;
      bus.proc_out_left  = 24'h00AAAA;
      bus.proc_out_right = 24'h00BBBB;
      bus.proc_done      = 1'b1;
      tick();
      bus.proc_done      = 1'b0;
      wait_idle("en_idle");
      tick(10);
      check("en_stay_idle", 64'(busy), 0);
      check("en_one_read", 64'(rd_cnt - r0), 1);
      check("en_one_write", 64'(wr_cnt - w0), 1);
      check("en_one_pv", 64'(pv_cnt - p0), 1);
      check("en_ovr", 64'(ocnt), 1);
      bus.read_ready = 1'b0;

      check("sb_empty", 64'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
